// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset controller: sequences FETCH/DECODE/EXEC/MEMACC/WB and
// drives datapath enables, mux selects, ALU op and a retired-instruction count.

package mc_defs_pkg;
  localparam logic [1:0] EXTOP_SIGNEXTEND = 2'd0;
  localparam logic [1:0] EXTOP_ZEROEXTEND = 2'd1;
endpackage

module mc_ctrl
  import mc_defs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        dmem_ack,
  output logic        pc_we,
  output logic        ir_we,
  output logic        rf_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [1:0]  extop,
  output logic        alusrc,
  output logic        regdst,
  output logic        memtoreg,
  output logic [2:0]  aluctl,
  output logic [1:0]  npc_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMACC = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_ADDU = 3'd0;
  localparam logic [2:0] ALU_SUBU = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JMP  = 2'd2;

  state_e      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [31:0] retired_q, retired_d;

  logic        is_r, r_ok, is_addiu, is_ori, is_lw, is_sw, is_beq, is_j, legal;
  logic [2:0]  alu_op;

  always_comb begin
    is_r     = (opcode == OP_RTYPE);
    is_addiu = (opcode == OP_ADDIU);
    is_ori   = (opcode == OP_ORI);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_beq   = (opcode == OP_BEQ);
    is_j     = (opcode == OP_J);
    r_ok     = 1'b0;
    alu_op   = ALU_ADDU;
    if (is_r) begin
      case (funct)
        FN_ADDU: begin r_ok = 1'b1; alu_op = ALU_ADDU; end
        FN_SUBU: begin r_ok = 1'b1; alu_op = ALU_SUBU; end
        FN_AND:  begin r_ok = 1'b1; alu_op = ALU_AND;  end
        FN_OR:   begin r_ok = 1'b1; alu_op = ALU_OR;   end
        FN_SLT:  begin r_ok = 1'b1; alu_op = ALU_SLT;  end
        default: begin r_ok = 1'b0; alu_op = ALU_ADDU; end
      endcase
    end else if (is_ori) begin
      alu_op = ALU_OR;
    end else if (is_beq) begin
      alu_op = ALU_SUBU;
    end
    legal = r_ok | is_addiu | is_ori | is_lw | is_sw | is_beq | is_j;
  end

  // Next state; every return to FETCH from a completed instruction retires it.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        if (is_j) begin
          state_d   = FETCH;
          retired_d = retired_q + 32'd1;
        end else if (legal) begin
          state_d = EXEC;
        end else begin
          state_d   = FETCH;
          illegal_d = 1'b1;
        end
      end
      EXEC: begin
        if (is_lw || is_sw) begin
          state_d = MEMACC;
        end else if (is_beq) begin
          state_d   = FETCH;
          retired_d = retired_q + 32'd1;
        end else if (r_ok || is_addiu || is_ori) begin
          state_d = WB;
        end else begin
          state_d = FETCH;
        end
      end
      MEMACC: begin
        if (dmem_ack) begin
          if (is_sw) begin
            state_d   = FETCH;
            retired_d = retired_q + 32'd1;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        state_d   = FETCH;
        retired_d = retired_q + 32'd1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Outputs are decoded from the current state; enables are gated by reset so
  // an access in flight is dropped the moment rst_n falls.
  always_comb begin
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    rf_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    npc_sel  = NPC_SEQ;
    aluctl   = alu_op;
    extop    = (is_ori && state_q != FETCH) ? EXTOP_ZEROEXTEND : EXTOP_SIGNEXTEND;
    alusrc   = (is_addiu || is_ori || is_lw || is_sw) &&
               (state_q == EXEC || state_q == MEMACC);
    case (state_q)
      FETCH: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
      end
      DECODE: begin
        if (is_j) begin
          pc_we   = 1'b1;
          npc_sel = NPC_JMP;
        end
      end
      EXEC: begin
        if (is_beq) begin
          pc_we   = zero;
          npc_sel = NPC_BR;
        end
      end
      MEMACC: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
      end
      WB: begin
        rf_we    = 1'b1;
        memtoreg = is_lw;
        regdst   = is_r;
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_we    = 1'b0;
      ir_we    = 1'b0;
      rf_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: each instruction's expected per-cycle behaviour is built
// from its class (phase list + per-phase outputs) and compared under a care mask.

module tb_mc_ctrl;
  import mc_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        zero, dmem_ack;
  logic        pc_we, ir_we, rf_we, dmem_req, dmem_we;
  logic [1:0]  extop;
  logic        alusrc, regdst, memtoreg;
  logic [2:0]  aluctl;
  logic [1:0]  npc_sel;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] retired;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .dmem_ack(dmem_ack), .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .extop(extop), .alusrc(alusrc),
    .regdst(regdst), .memtoreg(memtoreg), .aluctl(aluctl), .npc_sel(npc_sel),
    .state(state), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we, ir_we, rf_we, dreq, dwe;
    logic [1:0] ext;
    logic       asrc, rdst, m2r;
    logic [2:0] alu;
    logic [1:0] npc;
  } tr_t;

  tr_t         exp_q[$], msk_q[$], obs_q[$];
  int          ph_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mdl_retired;
  logic        mdl_illegal;

  function automatic tr_t cur_obs();
    tr_t o;
    o.st = state; o.pc_we = pc_we; o.ir_we = ir_we; o.rf_we = rf_we;
    o.dreq = dmem_req; o.dwe = dmem_we; o.ext = extop; o.asrc = alusrc;
    o.rdst = regdst; o.m2r = memtoreg; o.alu = aluctl; o.npc = npc_sel;
    return o;
  endfunction

  task automatic push_ph(input int ph, input tr_t e, input tr_t m);
    exp_q.push_back(e); msk_q.push_back(m); ph_q.push_back(ph);
  endtask

  // Reference: phase sequence and visible outputs derived from the instruction class.
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int waits);
    logic is_r, r_ok, addiu, ori, lw, sw, beq, j, legal;
    logic [2:0] aop;
    logic [1:0] ext_i;
    tr_t e, m, mb;
    is_r = (op == 6'h00); addiu = (op == 6'h09); ori = (op == 6'h0D);
    lw = (op == 6'h23); sw = (op == 6'h2B); beq = (op == 6'h04); j = (op == 6'h02);
    r_ok = is_r && (fn == 6'h21 || fn == 6'h23 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
    legal = r_ok | addiu | ori | lw | sw | beq | j;
    aop = 3'd0;
    if (ori) aop = 3'd3;
    if (beq) aop = 3'd1;
    if (r_ok) aop = (fn == 6'h21) ? 3'd0 : (fn == 6'h23) ? 3'd1 :
                    (fn == 6'h24) ? 3'd2 : (fn == 6'h25) ? 3'd3 : 3'd4;
    ext_i = ori ? EXTOP_ZEROEXTEND : EXTOP_SIGNEXTEND;
    exp_q.delete(); msk_q.delete(); ph_q.delete();
    mb = '0; mb.st = '1; mb.pc_we = 1'b1; mb.ir_we = 1'b1; mb.rf_we = 1'b1;
    mb.dreq = 1'b1; mb.dwe = 1'b1; mb.ext = '1;
    e = '0; e.st = 3'd0; e.pc_we = 1'b1; e.ir_we = 1'b1; e.ext = EXTOP_SIGNEXTEND;
    m = mb; m.npc = '1;
    push_ph(0, e, m);
    e = '0; e.st = 3'd1; e.ext = ext_i; m = mb;
    if (j) begin e.pc_we = 1'b1; e.npc = 2'd2; m.npc = '1; end
    push_ph(1, e, m);
    if (legal && !j) begin
      e = '0; e.st = 3'd2; e.ext = ext_i; e.asrc = addiu | ori | lw | sw; e.alu = aop;
      m = mb; m.asrc = 1'b1; m.alu = '1;
      if (beq) begin e.pc_we = z; e.npc = 2'd1; m.npc = '1; end
      push_ph(2, e, m);
      if (lw || sw) begin
        for (int k = 0; k <= waits; k++) begin
          e = '0; e.st = 3'd3; e.ext = ext_i; e.dreq = 1'b1; e.dwe = sw;
          e.asrc = 1'b1; e.alu = aop;
          m = mb; m.asrc = 1'b1; m.alu = '1;
          push_ph(3, e, m);
        end
      end
      if (!beq && !sw) begin
        e = '0; e.st = 3'd4; e.ext = ext_i; e.rf_we = 1'b1; e.m2r = lw; e.rdst = is_r;
        m = mb; m.rdst = 1'b1; m.m2r = 1'b1;
        push_ph(4, e, m);
      end
    end
    if (legal) mdl_retired = mdl_retired + 32'd1;
    else mdl_illegal = 1'b1;
  endtask

  // Starts one cycle after a rising edge with the DUT in FETCH; ends likewise.
  task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int waits);
    int last_mem;
    model_instr(op, fn, z, waits);
    obs_q.delete();
    last_mem = -1;
    foreach (ph_q[i]) if (ph_q[i] == 3) last_mem = i;
    opcode = op; funct = fn;
    for (int i = 0; i < exp_q.size(); i++) begin
      zero     = (ph_q[i] == 2) ? z : 1'($urandom);
      dmem_ack = (ph_q[i] == 3) ? (i == last_mem) : 1'($urandom);
      @(negedge clk);
      obs_q.push_back(cur_obs());
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; dmem_ack = 1'b0; zero = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    mdl_retired = '0; mdl_illegal = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dmem_ack = 1'b1; zero = 1'b1; opcode = 6'h23; funct = 6'h21;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (state !== 3'd0) $display("FAIL reset_state got %0d expected 0", state); else n_pass++;
    n_checks++;
    if (illegal !== 1'b0) $display("FAIL reset_illegal got %b expected 0", illegal); else n_pass++;
    n_checks++;
    if (retired !== 32'd0) $display("FAIL reset_retired got %0d expected 0", retired); else n_pass++;
    n_checks++;
    if ({pc_we, ir_we, rf_we, dmem_req, dmem_we} !== 5'b0)
      $display("FAIL reset_enables got %b expected 00000", {pc_we, ir_we, rf_we, dmem_req, dmem_we});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({state, pc_we, ir_we} !== 5'b000_11)
      $display("FAIL first_fetch got state=%0d pc_we=%b ir_we=%b expected 0/1/1", state, pc_we, ir_we);
    else n_pass++;
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_addu();
    exec_instr(6'h00, 6'h21, 1'b0, 0);
    foreach (obs_q[i]) begin
      n_checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i]))
        $display("FAIL addu cyc%0d got %h expected %h mask %h", i, obs_q[i], exp_q[i], msk_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (retired !== 32'd1) $display("FAIL addu_retired got %0d expected 1", retired); else n_pass++;
  endtask

  task automatic test_ori_addiu();
    logic [5:0] ops[2];
    ops[0] = 6'h0D; ops[1] = 6'h09;
    for (int t = 0; t < 2; t++) begin
      exec_instr(ops[t], 6'($urandom), 1'b0, 0);
      foreach (obs_q[i]) begin
        n_checks++;
        if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i]))
          $display("FAIL imm_op%h cyc%0d got %h expected %h mask %h", ops[t], i, obs_q[i], exp_q[i], msk_q[i]);
        else n_pass++;
      end
      n_checks++;
      if (retired !== mdl_retired) $display("FAIL imm_retired got %0d expected %0d", retired, mdl_retired);
      else n_pass++;
    end
  endtask

  task automatic test_lw_waits();
    exec_instr(6'h23, 6'h00, 1'b0, 3);
    foreach (obs_q[i]) begin
      n_checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i]))
        $display("FAIL lw cyc%0d got %h expected %h mask %h", i, obs_q[i], exp_q[i], msk_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (state !== 3'd0) $display("FAIL lw_end_state got %0d expected 0", state); else n_pass++;
  endtask

  task automatic test_beq_j();
    for (int t = 0; t < 3; t++) begin
      if (t < 2) exec_instr(6'h04, 6'($urandom), (t == 0), 0);
      else exec_instr(6'h02, 6'($urandom), 1'b0, 0);
      foreach (obs_q[i]) begin
        n_checks++;
        if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i]))
          $display("FAIL branch%0d cyc%0d got %h expected %h mask %h", t, i, obs_q[i], exp_q[i], msk_q[i]);
        else n_pass++;
      end
      n_checks++;
      if (retired !== mdl_retired) $display("FAIL branch%0d_retired got %0d expected %0d", t, retired, mdl_retired);
      else n_pass++;
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops[3], fns[3];
    ops[0] = 6'h3F; fns[0] = 6'h00;
    ops[1] = 6'h00; fns[1] = 6'h00;
    ops[2] = 6'h00; fns[2] = 6'h2A;
    for (int t = 0; t < 3; t++) begin
      exec_instr(ops[t], fns[t], 1'b0, 0);
      foreach (obs_q[i]) begin
        n_checks++;
        if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i]))
          $display("FAIL illegal%0d cyc%0d got %h expected %h mask %h", t, i, obs_q[i], exp_q[i], msk_q[i]);
        else n_pass++;
      end
      n_checks++;
      if (illegal !== mdl_illegal || retired !== mdl_retired)
        $display("FAIL illegal%0d_flags got ill=%b ret=%0d expected ill=%b ret=%0d",
                 t, illegal, retired, mdl_illegal, mdl_retired);
      else n_pass++;
    end
    do_reset();
    n_checks++;
    if (illegal !== 1'b0) $display("FAIL illegal_clear got %b expected 0", illegal); else n_pass++;
  endtask

  task automatic test_sw_abort();
    do_reset();
    opcode = 6'h2B; funct = 6'h00;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    n_checks++;
    if ({state, dmem_req, dmem_we} !== 5'b011_11)
      $display("FAIL sw_memacc got state=%0d req=%b we=%b expected 3/1/1", state, dmem_req, dmem_we);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dmem_req, dmem_we} !== 2'b00)
      $display("FAIL sw_abort_req got req=%b we=%b expected 0/0", dmem_req, dmem_we);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_retired = '0; mdl_illegal = 1'b0;
    n_checks++;
    if (state !== 3'd0 || retired !== 32'd0)
      $display("FAIL sw_abort_after got state=%0d retired=%0d expected 0/0", state, retired);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] op, fn, rf[5];
    rf[0] = 6'h21; rf[1] = 6'h23; rf[2] = 6'h24; rf[3] = 6'h25; rf[4] = 6'h2A;
    for (int t = 0; t < 40; t++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 9))
        0: begin op = 6'h00; fn = rf[$urandom_range(0, 4)]; end
        1: op = 6'h00;
        2: op = 6'h09;
        3: op = 6'h0D;
        4: op = 6'h23;
        5: op = 6'h2B;
        6: op = 6'h04;
        7: op = 6'h02;
        default: op = 6'($urandom);
      endcase
      exec_instr(op, fn, 1'($urandom), int'($urandom_range(0, 3)));
      foreach (obs_q[i]) begin
        n_checks++;
        if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i]))
          $display("FAIL rnd%0d op%h fn%h cyc%0d got %h expected %h mask %h",
                   t, op, fn, i, obs_q[i], exp_q[i], msk_q[i]);
        else n_pass++;
      end
      n_checks++;
      if (illegal !== mdl_illegal || retired !== mdl_retired)
        $display("FAIL rnd%0d_flags got ill=%b ret=%0d expected ill=%b ret=%0d",
                 t, illegal, retired, mdl_illegal, mdl_retired);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; dmem_ack = 1'b0;
    mdl_retired = '0; mdl_illegal = 1'b0;
    test_reset();
    test_addu();
    test_ori_addiu();
    test_lw_waits();
    test_beq_j();
    test_illegal();
    test_sw_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have no parameters; extop encodings SHALL be taken from the shared definitions header (EXTOP_SIGNEXTEND, EXTOP_ZEROEXTEND).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 funct  input  6  instruction bits [5:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 dmem_ack  input  1  data-memory access complete.
REQ-008 pc_we, ir_we, rf_we  output  1 each  PC, IR and register-file write enables.
REQ-009 dmem_req, dmem_we  output  1 each  data-memory request and write qualifier.
REQ-010 extop  output  2  extension-mode select to the extension unit.
REQ-011 alusrc, regdst, memtoreg  output  1 each  datapath muxes (1 = immediate, rd, memory data).
REQ-012 aluctl  output  3  ALU op: 0 addu, 1 subu, 2 and, 3 or, 4 slt.
REQ-013 npc_sel  output  2  next PC: 0 PC+4, 1 branch target, 2 jump target.
REQ-014 state  output  3  current FSM state; illegal  output  1  sticky illegal-instruction flag; retired  output  32  retired-instruction count.

Function
REQ-015 States: FETCH=0, DECODE=1, EXEC=2, MEMACC=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge.
REQ-016 FETCH: ir_we=1, pc_we=1, npc_sel=0; next DECODE.
REQ-017 DECODE: j (000010) -> pc_we=1, npc_sel=2, next FETCH; legal opcode -> EXEC; other opcode -> illegal set to 1, next FETCH, no write enable asserted.
REQ-018 Legal set: R-type (000000) with funct addu 100001, subu 100011, and 100100, or 100101, slt 101010; addiu 001001; ori 001101; lw 100011; sw 101011; beq 000100; j 000010; R-type with other funct SHALL count as illegal.
REQ-019 EXEC: R/addiu/ori -> WB; lw/sw -> MEMACC; beq -> aluctl=subu, pc_we=zero, npc_sel=1, next FETCH.
REQ-020 MEMACC: dmem_req=1, dmem_we=1 only for sw; stay while dmem_ack=0; on dmem_ack=1 sw -> FETCH, lw -> WB.
REQ-021 WB: rf_we=1; memtoreg=1 for lw only; regdst=1 for R-type only; next FETCH.
REQ-022 extop SHALL be EXTOP_ZEROEXTEND for ori and EXTOP_SIGNEXTEND for every other opcode and in FETCH.
REQ-023 alusrc=1 for addiu, ori, lw, sw in EXEC and MEMACC; aluctl=addu for addiu/lw/sw, or for ori, funct-decoded for R-type.
REQ-024 All outputs SHALL be Moore functions of state plus opcode/funct; no output depends on dmem_ack or zero, except pc_we in EXEC (zero) and the MEMACC exit.
REQ-025 retired SHALL increment by 1 on every transition into FETCH from DECODE (j only), EXEC, MEMACC or WB; illegal instructions SHALL NOT count; wraps 0xFFFFFFFF -> 0.
REQ-026 Latency in cycles: j 2, beq 3, R/addiu/ori 4, sw 4+waits, lw 5+waits, illegal 2.
REQ-027 dmem_ack outside MEMACC SHALL be ignored.

Reset
REQ-028 While rst_n=0 at an edge: state<=FETCH, illegal<=0, retired<=0.
REQ-029 While rst_n=0, all write enables and dmem_req SHALL be forced to 0 combinationally, including mid-MEMACC; the aborted instruction SHALL NOT be retired.
REQ-030 The first FETCH write enables SHALL occur in the first cycle with rst_n=1.

Verification
REQ-031 Reset then addu (opcode 0, funct 100001) -> states 0,1,2,4,0; rf_we=1 and regdst=1 only in cycle 4; retired=1.
REQ-032 ori -> extop=EXTOP_ZEROEXTEND in DECODE/EXEC/WB, alusrc=1, aluctl=3; addiu -> extop=EXTOP_SIGNEXTEND, aluctl=0.
REQ-033 lw with dmem_ack held 0 for 3 cycles -> MEMACC lasts 4 cycles with dmem_req=1, dmem_we=0; then WB with memtoreg=1; total 8 cycles.
REQ-034 beq with zero=1 -> pc_we=1, npc_sel=1 in EXEC; with zero=0 -> pc_we=0; both retire in 3 cycles.
REQ-035 opcode 111111 -> illegal=1 after DECODE, stays 1 through later legal instructions, retired unchanged; rst_n=0 clears it.
REQ-036 sw in MEMACC with rst_n pulled low for one cycle -> dmem_req=0 that cycle, state=FETCH next, retired=0.
